// File: rtl/ram_pkg.sv
// Shared types and elaboration-time parameter checks for the dual-port clearing RAM.
package ram_pkg;

  // Sweep controller states: CLEAR walks the array writing the clear value,
  // IDLE serves user reads and writes.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Read latency must be 1 or 2, and the array must fit the address space.
  function automatic bit params_ok(input int rd_lat, input int depth, input int addr_w);
    return ((rd_lat == 1) || (rd_lat == 2)) && (depth >= 1) && (depth <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Bare storage array: one write port, one registered read port.
module ram_dp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clock_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write and registered read; callers guarantee both addresses are below DEPTH.
  // NOTE: the array has no reset so it maps onto block RAM; the clear sweep gives it defined contents.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_dp_clear.sv
// Simple-dual-port RAM with hardware clear sweep, write-first bypass,
// optional second read stage and a read-valid flag.
module ram_dp_clear
  import ram_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 8,
  parameter int              DEPTH     = 2**ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int              RD_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic              busy,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data,
  input  logic              rden,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  if (!params_ok(RD_LAT, DEPTH, ADDR_W)) begin : g_bad_params
    $error("ram_dp_clear: RD_LAT must be 1 or 2 and DEPTH must not exceed 2**ADDR_W");
  end

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              user_wr;
  logic              user_rd;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] core_rdata;

  logic              rd_v1_q;
  logic              zero_q;
  logic              byp_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] rd_res;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
  // User traffic is only accepted once the sweep has finished.
  assign user_wr     = (state_q == IDLE) && wren && wr_in_range;
  assign user_rd     = (state_q == IDLE) && rden;

  // Sweep FSM: walks ptr over every word after reset or an accepted clear request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clear) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
      endcase
    end
  end

  // Write-port mux: the sweep owns the port while it runs, otherwise the user does.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = CLEAR_VAL;
    end else if (user_wr) begin
      mem_we = 1'b1;
    end
  end

  ram_dp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clock_i (clock),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (user_rd && rd_in_range),
    .raddr_i (rd_addr),
    .rdata_o (core_rdata)
  );

  // First read stage: remember how the issued read must be resolved (zero, bypass or array).
  // zero_q resets high so q reads 0 after reset whatever the array register holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1_q    <= 1'b0;
      zero_q     <= 1'b1;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_v1_q <= user_rd;
      if (user_rd) begin
        zero_q     <= !rd_in_range;
        byp_q      <= user_wr && (wr_addr == rd_addr);
        byp_data_q <= data;
      end
    end
  end

  // Flags and array register only change on an accepted read, so rd_res holds between reads.
  assign rd_res = zero_q ? '0 : (byp_q ? byp_data_q : core_rdata);

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] q2_q;
    logic              v2_q;

    // Second read stage: captures the resolved result one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= rd_v1_q;
        if (rd_v1_q) q2_q <= rd_res;
      end
    end

    assign q       = q2_q;
    assign q_valid = v2_q;
  end else begin : g_lat1
    assign q       = rd_res;
    assign q_valid = rd_v1_q;
  end

  assign busy = busy_q;

endmodule
